divu_arbiter: RTL and testbench

Round-robin scheduler that shares one iterative fixed-point divider (`divu`-style start/busy/done interface) among `NREQ` requesters. It accepts requests and registers the winner's operands, then pulses the divider start. It waits for the divider's done, then returns the quotient and status tagged with the requester ID. It sits between the datapath clients and the single divider instance, so area-expensive division is time-multiplexed.

---
 rtl/divu_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_divu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divu_arbiter.sv
// divu_arbiter: round-robin scheduler sharing one iterative divider among NREQ requesters.
// Latency: ack 1 cycle after a request is seen in IDLE, divider start 1 cycle later, response 1 cycle after divider done.
// Backpressure: requesters hold REQ_VLD_I until acked; only IDLE grants. Optional WAIT watchdog: DIVU_ARB_TIMEOUT_EN.
module divu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLK_I,
    input  logic                  RST_N_I,
    input  logic [NREQ-1:0]       REQ_VLD_I,
    input  logic [NREQ*WIDTH-1:0] REQ_DIVIDEND_I,
    input  logic [NREQ*WIDTH-1:0] REQ_DIVISOR_I,
    output logic [NREQ-1:0]       REQ_ACK_O,
    output logic                  RSP_VLD_O,
    output logic [IDW-1:0]        RSP_ID_O,
    output logic [WIDTH-1:0]      RSP_QUOTIENT_O,
    output logic [1:0]            RSP_STATUS_O,
    output logic                  BUSY_O,
    output logic                  DIV_READY_O,
    output logic [WIDTH-1:0]      DIV_DIVIDEND_O,
    output logic [WIDTH-1:0]      DIV_DIVISOR_O,
    input  logic                  DIV_DONE_I,
    input  logic                  DIV_VLD_I,
    input  logic                  DIV_DBZ_I,
    input  logic                  DIV_OVF_I,
    input  logic [WIDTH-1:0]      DIV_QUOTIENT_I
);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_OVF = 2'b01;
    localparam logic [1:0] ST_DBZ = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [NREQ-1:0]   r_ack;
    logic              r_div_ready;
    logic [WIDTH-1:0]  r_div_dvd;
    logic [WIDTH-1:0]  r_div_dvs;
    logic [IDW-1:0]    r_gnt_id;
    logic [IDW-1:0]    r_last_grant;
    logic              r_rsp_vld;
    logic [IDW-1:0]    r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_q;
    logic [1:0]        r_rsp_status;

    logic [WIDTH-1:0]  w_req_dvd [NREQ];
    logic [WIDTH-1:0]  w_req_dvs [NREQ];

    logic              w_hi_found;
    logic [IDW-1:0]    w_hi_idx;
    logic              w_lo_found;
    logic [IDW-1:0]    w_lo_idx;
    logic              w_gnt_vld;
    logic [IDW-1:0]    w_gnt_idx;
    logic [NREQ-1:0]   w_gnt_onehot;

    logic              w_grant;
    logic              w_done_take;
    logic              w_tmo_take;
    logic              w_timeout;
    logic [1:0]        w_status;

    // Unpack the flat operand buses into per-requester words.
    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign w_req_dvd[k] = REQ_DIVIDEND_I[k*WIDTH +: WIDTH];
        assign w_req_dvs[k] = REQ_DIVISOR_I[k*WIDTH +: WIDTH];
    end

    // Round-robin pick: lowest requester above last_grant, else lowest at or below it (wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (REQ_VLD_I[IDW'(j)]) begin
                if (IDW'(j) > r_last_grant) begin
                    if (!w_hi_found) begin
                        w_hi_found = 1'b1;
                        w_hi_idx   = IDW'(j);
                    end
                end else if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = IDW'(j);
                end
            end
        end
        w_gnt_vld    = w_hi_found | w_lo_found;
        w_gnt_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
        w_gnt_onehot = NREQ'(1) << w_gnt_idx;
    end

    // Divider status priority: divide-by-zero wins over overflow.
    always_comb begin
        w_status = ST_OK;
        if (DIV_DBZ_I) begin
            w_status = ST_DBZ;
        end else if (DIV_OVF_I) begin
            w_status = ST_OVF;
        end
    end

`ifdef DIVU_ARB_TIMEOUT_EN
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNTW-1:0] r_wait_cnt;

    // Watchdog: counts cycles spent in WAIT, cleared whenever the FSM is elsewhere.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign w_timeout = (r_wait_cnt == CNTW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and one-cycle action strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done_take = 1'b0;
        w_tmo_take  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (DIV_DONE_I) begin
                    w_done_take = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_tmo_take  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture at grant, start pulse, response capture; all outputs registered.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_ack        <= '0;
            r_div_ready  <= 1'b0;
            r_div_dvd    <= '0;
            r_div_dvs    <= '0;
            r_gnt_id     <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_rsp_vld    <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_q      <= '0;
            r_rsp_status <= ST_OK;
        end else begin
            r_ack       <= '0;
            r_div_ready <= (r_state == S_ISSUE);
            r_rsp_vld   <= 1'b0;
            if (w_grant) begin
                r_ack     <= w_gnt_onehot;
                r_div_dvd <= w_req_dvd[w_gnt_idx];
                r_div_dvs <= w_req_dvs[w_gnt_idx];
                r_gnt_id  <= w_gnt_idx;
            end
            if (w_done_take) begin
                r_rsp_vld    <= 1'b1;
                r_rsp_id     <= r_gnt_id;
                r_rsp_status <= w_status;
                // Quotient only meaningful on a clean, valid result.
                r_rsp_q      <= ((w_status == ST_OK) && DIV_VLD_I) ? DIV_QUOTIENT_I : '0;
            end
            if (w_tmo_take) begin
                r_rsp_vld    <= 1'b1;
                r_rsp_id     <= r_gnt_id;
                r_rsp_status <= ST_TMO;
                r_rsp_q      <= '0;
            end
            // Priority rotates only once the operation has actually responded.
            if (r_state == S_RESP) begin
                r_last_grant <= r_gnt_id;
            end
        end
    end

    assign REQ_ACK_O      = r_ack;
    assign RSP_VLD_O      = r_rsp_vld;
    assign RSP_ID_O       = r_rsp_id;
    assign RSP_QUOTIENT_O = r_rsp_q;
    assign RSP_STATUS_O   = r_rsp_status;
    assign BUSY_O         = (r_state != S_IDLE);
    assign DIV_READY_O    = r_div_ready;
    assign DIV_DIVIDEND_O = r_div_dvd;
    assign DIV_DIVISOR_O  = r_div_dvs;

endmodule

// File: tb/tb_divu_arbiter.sv
// tb_divu_arbiter: randomized and directed checks of divu_arbiter against a queue-free behavioural model.
// Divider is emulated inline: fixed-point (FBITS) unsigned divide with selectable done latency.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_divu_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int FBITS = 18;
    localparam int TMO   = 10;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_vld = '0;
    logic [NREQ*WIDTH-1:0] dvd_bus;
    logic [NREQ*WIDTH-1:0] dvs_bus;
    logic [NREQ-1:0]       ack;
    logic                  rsp_vld;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_q;
    logic [1:0]            rsp_st;
    logic                  busy;
    logic                  div_ready;
    logic [WIDTH-1:0]      div_dvd;
    logic [WIDTH-1:0]      div_dvs;
    logic                  div_done = 1'b0;
    logic                  div_vld = 1'b0;
    logic                  div_dbz = 1'b0;
    logic                  div_ovf = 1'b0;
    logic [WIDTH-1:0]      div_q = '0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] m_dvd [NREQ];
    logic [WIDTH-1:0] m_dvs [NREQ];
    int               m_last = NREQ - 1;
    logic [1:0]       m_rsp_id = '0;
    logic [WIDTH-1:0] m_rsp_q = '0;
    logic [1:0]       m_rsp_st = '0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NREQ; k++) begin : g_bus
        assign dvd_bus[k*WIDTH +: WIDTH] = m_dvd[k];
        assign dvs_bus[k*WIDTH +: WIDTH] = m_dvs[k];
    end

    divu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .CLK_I(clk), .RST_N_I(rst_n),
        .REQ_VLD_I(req_vld), .REQ_DIVIDEND_I(dvd_bus), .REQ_DIVISOR_I(dvs_bus),
        .REQ_ACK_O(ack), .RSP_VLD_O(rsp_vld), .RSP_ID_O(rsp_id),
        .RSP_QUOTIENT_O(rsp_q), .RSP_STATUS_O(rsp_st), .BUSY_O(busy),
        .DIV_READY_O(div_ready), .DIV_DIVIDEND_O(div_dvd), .DIV_DIVISOR_O(div_dvs),
        .DIV_DONE_I(div_done), .DIV_VLD_I(div_vld), .DIV_DBZ_I(div_dbz),
        .DIV_OVF_I(div_ovf), .DIV_QUOTIENT_I(div_q)
    );

    // Round-robin rule: first set bit scanning upward from last+1 with wrap.
    function automatic int next_grant(input logic [NREQ-1:0] m, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (m[2'((last + i) % NREQ)]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_vld = '0; div_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last = NREQ - 1; m_rsp_id = '0; m_rsp_q = '0; m_rsp_st = '0;
        @(negedge clk);
    endtask

    task automatic set_operands(input int k);
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) begin
            m_dvd[k] = $urandom; m_dvs[k] = '0;
        end else if (sel == 1) begin
            m_dvd[k] = $urandom | 32'h8000_0000; m_dvs[k] = $urandom_range(1, 255);
        end else begin
            m_dvd[k] = $urandom; m_dvs[k] = $urandom | 32'h0004_0000;
        end
    endtask

    // One full operation: grant, start, divider done after lat cycles, response.
    task automatic serve_one(input int lat, input bit hold, input logic [NREQ-1:0] wd_mask,
                             output int got_id, output int ack_wait);
        int exp_id;
        bit seen, dbz, ovf;
        logic [WIDTH-1:0] a, b, eq, stub_q;
        logic [63:0] full;
        logic [1:0] es;
        exp_id = next_grant(req_vld, m_last);
        got_id = -1; ack_wait = 0; seen = 1'b0;
        if (exp_id < 0) exp_id = 0;
        a = m_dvd[exp_id]; b = m_dvs[exp_id];
        while (!seen && ack_wait < 20) begin
            @(negedge clk);
            ack_wait++;
            if (ack !== '0) seen = 1'b1;
        end
        n_checks++;
        if (ack !== (4'b0001 << exp_id)) $display("FAIL grant_ack: ack=%b required %b", ack, 4'b0001 << exp_id);
        else n_pass++;
        for (int k = 0; k < NREQ; k++) if (ack[2'(k)]) got_id = k;
        n_checks++;
        if ({rsp_id, rsp_q, rsp_st} !== {m_rsp_id, m_rsp_q, m_rsp_st})
            $display("FAIL rsp_hold: id=%0d q=%h st=%b required id=%0d q=%h st=%b", rsp_id, rsp_q, rsp_st, m_rsp_id, m_rsp_q, m_rsp_st);
        else n_pass++;
        if (!seen) return;
        if (!hold) req_vld[2'(exp_id)] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ack, div_ready, div_dvd, div_dvs} !== {4'b0000, 1'b1, a, b})
            $display("FAIL issue: ack=%b rdy=%b dvd=%h dvs=%h required ack=0000 rdy=1 dvd=%h dvs=%h", ack, div_ready, div_dvd, div_dvs, a, b);
        else n_pass++;
        dbz  = (b == '0);
        full = dbz ? 64'd0 : (({32'd0, a} << FBITS) / {32'd0, b});
        ovf  = !dbz && (full[63:32] != 32'd0);
        es   = dbz ? 2'b10 : (ovf ? 2'b01 : 2'b00);
        eq   = (es == 2'b00) ? full[31:0] : '0;
        stub_q = dbz ? WIDTH'($urandom) : full[31:0];
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_vld = req_vld | wd_mask;
                n_checks++;
                if (div_ready !== 1'b0) $display("FAIL ready_pulse: rdy=%b required 0", div_ready);
                else n_pass++;
            end
            n_checks++;
            if ({rsp_vld, busy} !== 2'b01) $display("FAIL wait_quiet: rsp_vld=%b busy=%b required 0 1", rsp_vld, busy);
            else n_pass++;
            if (k == lat) begin
                req_vld  = req_vld & ~wd_mask;
                div_done = 1'b1; div_dbz = dbz; div_ovf = ovf;
                div_vld  = !dbz && !ovf; div_q = stub_q;
            end
        end
        @(negedge clk);
        div_done = 1'b0; div_dbz = 1'b0; div_ovf = 1'b0; div_vld = 1'b0; div_q = '0;
        n_checks++;
        if ({rsp_vld, rsp_id, rsp_q, rsp_st} !== {1'b1, 2'(exp_id), eq, es})
            $display("FAIL response: vld=%b id=%0d q=%h st=%b required vld=1 id=%0d q=%h st=%b", rsp_vld, rsp_id, rsp_q, rsp_st, exp_id, eq, es);
        else n_pass++;
        m_last = exp_id; m_rsp_id = 2'(exp_id); m_rsp_q = eq; m_rsp_st = es;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({ack, rsp_vld, rsp_id, rsp_q, rsp_st, busy, div_ready, div_dvd, div_dvs} !== '0)
            $display("FAIL reset_state: outputs not all zero (busy=%b ack=%b)", busy, ack);
        else n_pass++;
        do_reset();
        n_checks++;
        if ({busy, rsp_vld, ack} !== '0) $display("FAIL reset_release: busy=%b rsp=%b ack=%b required 0", busy, rsp_vld, ack);
        else n_pass++;
    endtask

    task automatic test_single_op();
        int id, aw;
        m_dvd[1] = 32'h0018_0000; m_dvs[1] = 32'h0008_0000;
        req_vld = 4'b0010;
        serve_one(6, 1'b0, '0, id, aw);
        n_checks++;
        if (aw !== 1 || rsp_q !== 32'h000C_0000 || id !== 1)
            $display("FAIL single_op: ack_delay=%0d id=%0d q=%h required 1 1 000c0000", aw, id, rsp_q);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int id, aw;
        do_reset();
        for (int k = 0; k < NREQ; k++) set_operands(k);
        req_vld = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            serve_one($urandom_range(1, 6), 1'b1, '0, id, aw);
            n_checks++;
            if (id !== i % NREQ) $display("FAIL fairness: op %0d id=%0d required %0d", i, id, i % NREQ);
            else n_pass++;
        end
        req_vld = '0;
    endtask

    task automatic test_dbz_ovf();
        int id, aw;
        m_dvd[2] = 32'h1234_5678; m_dvs[2] = '0;
        req_vld = 4'b0100;
        serve_one(1, 1'b0, '0, id, aw);
        n_checks++;
        if ({rsp_st, rsp_q, aw} !== {2'b10, 32'h0, 32'd2}) $display("FAIL dbz: st=%b q=%h ack_delay=%0d required 10 0 2", rsp_st, rsp_q, aw);
        else n_pass++;
        m_dvd[3] = 32'h7FFF_FFFF; m_dvs[3] = 32'h0000_0001;
        req_vld = 4'b1000;
        serve_one($urandom_range(2, 9), 1'b0, '0, id, aw);
        n_checks++;
        if ({rsp_st, rsp_q} !== {2'b01, 32'h0}) $display("FAIL overflow: st=%b q=%h required 01 0", rsp_st, rsp_q);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        int id, aw, cyc, n_rsp;
        m_dvd[2] = 32'd1; m_dvs[2] = 32'd1;
        req_vld = 4'b0100;
        cyc = 0;
        while (ack === '0 && cyc < 10) begin @(negedge clk); cyc++; end
        req_vld = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ack, rsp_vld, rsp_id, rsp_q, rsp_st, busy, div_ready, div_dvd, div_dvs} !== '0)
            $display("FAIL reset_midop: outputs not zero (busy=%b id=%0d st=%b)", busy, rsp_id, rsp_st);
        else n_pass++;
        m_last = NREQ - 1; m_rsp_id = '0; m_rsp_q = '0; m_rsp_st = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_rsp = 0;
        for (int k = 0; k < 5; k++) begin @(negedge clk); if (rsp_vld === 1'b1) n_rsp++; end
        n_checks++;
        if (n_rsp !== 0) $display("FAIL reset_no_rsp: responses=%0d required 0", n_rsp);
        else n_pass++;
        m_dvd[0] = 32'h0030_0000; m_dvs[0] = 32'h0010_0000;
        m_dvd[3] = 32'h0001_0000; m_dvs[3] = 32'h0004_0000;
        req_vld = 4'b1001;
        serve_one(5, 1'b0, '0, id, aw);
        n_checks++;
        if (id !== 0) $display("FAIL reset_priority: id=%0d required 0", id);
        else n_pass++;
        serve_one(3, 1'b0, '0, id, aw);
        n_checks++;
        if ({id, rsp_q} !== {32'd3, 32'h0001_0000}) $display("FAIL after_reset: id=%0d q=%h required 3 00010000", id, rsp_q);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int id, aw;
        logic [NREQ-1:0] wd;
        for (int n = 0; n < 40; n++) begin
            if (req_vld == '0 || $urandom_range(0, 1) == 1) begin
                for (int k = 0; k < NREQ; k++)
                    if (!req_vld[2'(k)] && $urandom_range(0, 1) == 1) begin set_operands(k); req_vld[2'(k)] = 1'b1; end
                if (req_vld == '0) begin id = $urandom_range(0, NREQ - 1); set_operands(id); req_vld[2'(id)] = 1'b1; end
            end
            wd = NREQ'($urandom) & ~req_vld;
            for (int k = 0; k < NREQ; k++) if (wd[2'(k)]) set_operands(k);
            serve_one($urandom_range(1, 12), 1'b0, wd, id, aw);
            n_checks++;
            if (aw !== 2) $display("FAIL back_to_back: op %0d ack_delay=%0d required 2", n, aw);
            else n_pass++;
        end
        req_vld = '0;
    endtask

    task automatic test_timeout();
        int cyc, first, n_rsp;
        m_dvd[1] = 32'd5; m_dvs[1] = 32'd7;
        req_vld = 4'b0010;
        cyc = 0;
        while (ack === '0 && cyc < 10) begin @(negedge clk); cyc++; end
        req_vld = '0;
        @(negedge clk);
        first = -1; n_rsp = 0;
`ifdef DIVU_ARB_TIMEOUT_EN
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (rsp_vld === 1'b1 && first < 0) begin
                first = k;
                n_checks++;
                if ({rsp_id, rsp_q, rsp_st} !== {2'd1, 32'h0, 2'b11})
                    $display("FAIL timeout_rsp: id=%0d q=%h st=%b required 1 0 11", rsp_id, rsp_q, rsp_st);
                else n_pass++;
            end
        end
        n_checks++;
        if (first !== TMO) $display("FAIL timeout_delay: response after %0d cycles required %0d", first, TMO);
        else n_pass++;
`else
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (rsp_vld === 1'b1) n_rsp++;
        end
        n_checks++;
        if ({n_rsp, busy} !== {32'd0, 1'b1}) $display("FAIL no_timeout: responses=%0d busy=%b required 0 1", n_rsp, busy);
        else n_pass++;
`endif
        do_reset();
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) begin m_dvd[k] = '0; m_dvs[k] = '0; end
        test_reset();
        test_single_op();
        test_fairness();
        test_dbz_ovf();
        test_reset_midop();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
